// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and state/mode types for the memory DMA engine.
package mem_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mem_dma_state_t;
   typedef enum logic {FILL, COPY} mem_dma_mode_t;
endpackage

// File: rtl/Memory32x16.sv
// Memory32x16: 64K x 32 single-port memory, combinational read, clocked write.
module Memory32x16 (
   input  logic        clk,
   input  logic [15:0] addr,
   input  logic        we,
   input  logic [31:0] data_in,
   output logic [31:0] data_out
);
   logic [31:0] mem [0:65535];
   always_ff @(posedge clk)
      if (we) mem[addr] <= data_in;
   assign data_out = mem[addr];
endmodule

// File: rtl/mem_dma_engine.sv
// mem_dma_engine: fill/copy block-transfer engine owning the memory port,
// with a host pass-through port while idle.
module mem_dma_engine #(
   parameter int ADDR_W = mem_pkg::ADDR_W,
   parameter int DATA_W = mem_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] fill_value,
   output logic              busy,
   output logic              done,
   input  logic              host_valid,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ready,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   import mem_pkg::*;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   mem_dma_state_t    state;
   mem_dma_mode_t     mode_q;
   logic [ADDR_W-1:0] src, dst;
   logic [ADDR_W:0]   rem;
   logic [DATA_W-1:0] value, data_q;
   logic              idle;
   assign idle       = state == IDLE;
   assign busy       = !idle;
   assign done       = state == DONE;
   // reset blocks the port combinationally so no write slips through mid-transfer
   assign host_ready = idle && !rst;
   assign host_rdata = mem_rdata;
   assign mem_addr   = idle ? host_addr : (state == READ ? src : dst);
   assign mem_we     = !rst && (idle ? host_valid && host_we : state == WRITE);
   assign mem_wdata  = idle ? host_wdata : (mode_q == COPY ? data_q : value);
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= FILL;
         src    <= '0;
         dst    <= '0;
         rem    <= '0;
         value  <= '0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               mode_q <= mem_dma_mode_t'(mode);
               src    <= src_addr;
               dst    <= dst_addr;
               rem    <= len;
               value  <= fill_value;
               state  <= len == '0 ? DONE : (mode ? READ : WRITE);
            end
            READ: begin
               data_q <= mem_rdata;
               src    <= src + ADDR_ONE;
               state  <= WRITE;
            end
            WRITE: begin
               dst   <= dst + ADDR_ONE;
               rem   <= rem - REM_ONE;
               state <= rem == REM_ONE ? DONE : (mode_q == COPY ? READ : WRITE);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_dma_engine.sv
// tb_mem_dma_engine: directed checks of fill, copy, wrap, host port, len=0 and reset.
module tb_mem_dma_engine;
   logic        clk = 0, rst = 1, start = 0, mode = 0;
   logic [15:0] src_addr = 0, dst_addr = 0, host_addr = 0, mem_addr;
   logic [16:0] len = 0;
   logic [31:0] fill_value = 0, host_wdata = 0, host_rdata, mem_wdata, mem_rdata;
   logic        busy, done, host_valid = 0, host_we = 0, host_ready, mem_we;
   int          n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   mem_dma_engine dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .fill_value(fill_value), .busy(busy), .done(done),
      .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );
   Memory32x16 u_mem (.clk(clk), .addr(mem_addr), .we(mem_we), .data_in(mem_wdata), .data_out(mem_rdata));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hwr(input logic [15:0] a, input logic [31:0] d);
      host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
      tick();
      host_valid = 0; host_we = 0;
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
      host_valid = 1; host_we = 0; host_addr = a;
      #1;
      chk(tag, host_rdata, exp);
      host_valid = 0;
   endtask

   task automatic go(input logic m, input logic [15:0] s, input logic [15:0] d,
                     input logic [16:0] l, input logic [31:0] v);
      start = 1; mode = m; src_addr = s; dst_addr = d; len = l; fill_value = v;
      tick();
      start = 0;
   endtask

   initial begin
      // reset: host write attempt must not reach memory
      host_valid = 1; host_we = 1; host_addr = 16'h0020; host_wdata = 32'h1;
      tick(); tick();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      rst = 0; host_valid = 0; host_we = 0;
      #1;
      chk("idle_host_ready", host_ready, 1);

      // FILL 4 words at 0x0010
      hwr(16'h000F, 32'h0F0F); hwr(16'h0014, 32'h1414);
      go(0, 0, 16'h0010, 4, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         chk("fill_busy", busy, 1);
         chk("fill_done_early", done, 0);
         chk("fill_we", mem_we, 1);
         chk("fill_addr", mem_addr, 32'h10 + i);
         tick();
      end
      chk("fill_done", done, 1);
      chk("fill_busy_done", busy, 1);
      tick();
      chk("fill_idle", busy, 0);
      chk("fill_done_clr", done, 0);
      rd("fill_0f", 16'h000F, 32'h0F0F);
      for (int i = 0; i < 4; i++) rd("fill_word", 16'h0010 + 16'(i), 32'hDEADBEEF);
      rd("fill_14", 16'h0014, 32'h1414);

      // COPY 3 words 0x0100 -> 0x0200
      hwr(16'h0100, 1); hwr(16'h0101, 2); hwr(16'h0102, 3);
      go(1, 16'h0100, 16'h0200, 3, 0);
      for (int i = 0; i < 6; i++) begin
         chk("copy_done_early", done, 0);
         tick();
      end
      chk("copy_done", done, 1);
      tick();
      for (int i = 0; i < 3; i++) rd("copy_word", 16'h0200 + 16'(i), i + 1);

      // FILL wrapping past 0xFFFF
      hwr(16'h0001, 32'h1111);
      go(0, 0, 16'hFFFE, 3, 32'h5A5A5A5A);
      tick(); tick(); tick();
      chk("wrap_done", done, 1);
      tick();
      rd("wrap_fffe", 16'hFFFE, 32'h5A5A5A5A);
      rd("wrap_ffff", 16'hFFFF, 32'h5A5A5A5A);
      rd("wrap_0000", 16'h0000, 32'h5A5A5A5A);
      rd("wrap_0001", 16'h0001, 32'h1111);

      // host write in start cycle, host read while busy, start while busy
      hwr(16'h0400, 32'h4444);
      host_valid = 1; host_we = 1; host_addr = 16'h0005; host_wdata = 32'hCAFE;
      #1;
      chk("start_host_ready", host_ready, 1);
      go(0, 0, 16'h0300, 2, 7);
      host_we = 0; host_addr = 16'h0005;
      start = 1; dst_addr = 16'h0400; len = 1; fill_value = 32'h99;
      #1;
      chk("busy_host_ready", host_ready, 0);
      chk("busy_port_addr", mem_addr, 32'h0300);
      tick();
      start = 0;
      chk("busy_host_ready2", host_ready, 0);
      tick();
      chk("host_done", done, 1);
      chk("host_ready_done", host_ready, 0);
      tick();
      chk("host_ready_after", host_ready, 1);
      chk("host_rdata_after", host_rdata, 32'hCAFE);
      host_valid = 0;
      tick();
      chk("no_second_xfer", busy, 0);
      rd("no_second_0400", 16'h0400, 32'h4444);
      rd("host_fill_300", 16'h0300, 7);
      rd("host_fill_301", 16'h0301, 7);

      // len = 0
      go(0, 0, 16'h0800, 0, 32'hFFFF);
      chk("len0_done", done, 1);
      chk("len0_we", mem_we, 0);
      tick();
      chk("len0_idle", busy, 0);

      // reset mid-COPY after 2 of 5 words
      for (int i = 0; i < 5; i++) begin
         hwr(16'h0500 + 16'(i), 32'hA0 + i);
         hwr(16'h0600 + 16'(i), 32'hB0 + i);
      end
      go(1, 16'h0500, 16'h0600, 5, 0);
      tick(); tick(); tick(); tick();
      rst = 1;
      #1;
      chk("midrst_we", mem_we, 0);
      chk("midrst_ready", host_ready, 0);
      tick();
      rst = 0;
      #1;
      chk("postrst_busy", busy, 0);
      chk("postrst_done", done, 0);
      chk("postrst_we", mem_we, 0);
      rd("midrst_600", 16'h0600, 32'hA0);
      rd("midrst_601", 16'h0601, 32'hA1);
      rd("midrst_602", 16'h0602, 32'hB2);
      rd("midrst_603", 16'h0603, 32'hB3);
      rd("midrst_604", 16'h0604, 32'hB4);
      go(0, 0, 16'h0700, 1, 32'h77);
      chk("fresh_busy", busy, 1);
      tick();
      chk("fresh_done", done, 1);
      tick();
      rd("fresh_700", 16'h0700, 32'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_dma_engine.md
# mem_dma_engine

Block-transfer engine sitting directly upstream of the 32-bit × 64K-word single-port memory and owning its only port. It performs word-granular fill and copy operations, and passes a host access port through to the memory when idle. Because the memory reads combinationally and writes on the clock edge, this engine is the memory's sole driver. It replaces bulk clearing at reset with a bounded, software-visible fill.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 32, memory word width.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a transfer; sampled only in IDLE.
- mode  in  1  0 = FILL, 1 = COPY; sampled with start.
- src_addr  in  ADDR_W  COPY source base; sampled with start.
- dst_addr  in  ADDR_W  destination base; sampled with start.
- len  in  ADDR_W+1  word count, 0..65536; sampled with start.
- fill_value  in  DATA_W  FILL data; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- host_valid  in  1  host access request.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host access accepted this cycle.
- host_rdata  out  DATA_W  host read data, combinational from mem_rdata.
- mem_addr  out  ADDR_W  to memory addr.
- mem_we  out  1  to memory we.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out; combinational read.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE
  - host_ready = 1 and host_rdata = mem_rdata.
  - mem_addr = host_addr, mem_wdata = host_wdata, mem_we = host_valid & host_we.
  - start with len = 0 → DONE; no memory writes.
  - start, FILL, len > 0 → WRITE.
  - start, COPY, len > 0 → READ.
  - Operands latch into internal src/dst/remaining/value registers.
  - A host access in the same cycle as start completes normally.
- READ (COPY only)
  - mem_addr = src, mem_we = 0.
  - mem_rdata is captured into a data register.
  - src increments; next state is WRITE.
- WRITE
  - mem_addr = dst, mem_we = 1.
  - mem_wdata = fill_value (FILL) or the data register (COPY).
  - dst increments and remaining decrements.
  - If remaining was 1 → DONE; otherwise COPY → READ, FILL stays in WRITE.
- DONE: done = 1 for exactly one cycle, then → IDLE.
- Outside IDLE: host_ready = 0 and host inputs have no effect on the memory. The host holds its request (valid/ready semantics).
- start outside IDLE is ignored; it is neither queued nor an error.
- Addresses wrap modulo 2^ADDR_W; 0xFFFF + 1 = 0x0000.
- len = 65536 covers the whole memory.
- COPY is strictly ascending, word by word, with no overlap handling.
  - If dst is in the range (src, src+len), source words are overwritten before they are read; this is the defined behaviour.
- Reset applies in any state, including mid-transfer:
  - next state IDLE; busy = 0, done = 0; internal registers cleared.
  - While rst = 1: mem_we = 0 and host_ready = 0.
  - Memory contents already written are kept; there is no rollback.

## Timing
- Let start be sampled at edge k. Cycle k+1 is the first cycle in READ or WRITE.
- FILL of N words: writes occur at edges k+1..k+N; done is high during cycle k+N+1.
- COPY of N words: 2 cycles per word; the last write occurs at edge k+2N; done is high during cycle k+2N+1.
- len = 0: done is high during cycle k+1.
- The next start is accepted in the cycle after done; back-to-back transfers lose 1 idle cycle.
- Host read latency is 0 (combinational); a host write commits at the edge where host_ready & host_valid & host_we.

## Structure
- Shared package mem_pkg holds:
  - ADDR_W and DATA_W defaults;
  - mem_dma_state_t enum {IDLE, READ, WRITE, DONE};
  - mem_dma_mode_t enum {FILL, COPY}.
- The memory-port mux is a few assigns inside this module; no sub-module.
- The bench instantiates mem_dma_engine driving Memory32x16.

## Test plan
- FILL: dst = 0x0010, len = 4, value 0xDEADBEEF.
  - Words 0x10..0x13 = 0xDEADBEEF; 0x0F and 0x14 unchanged.
  - done at cycle k+5; busy high for cycles k+1..k+5.
- COPY: preload 0x0100..0x0102 = 1, 2, 3; src = 0x0100, dst = 0x0200, len = 3.
  - 0x0200..0x0202 = 1, 2, 3; done at cycle k+7.
- Wrap: FILL dst = 0xFFFE, len = 3, value 0x5A5A5A5A.
  - 0xFFFE, 0xFFFF, 0x0000 written; 0x0001 untouched.
- Host interaction:
  - Host write 0xCAFE to 0x0005 in the start cycle → committed.
  - Host read during busy → host_ready = 0; completes the cycle after done.
  - start pulsed while busy → no second transfer.
- len = 0 → done at cycle k+1, no mem_we.
- Reset mid-COPY after 2 of 5 words:
  - busy = 0 and mem_we = 0 next cycle; only the first 2 destination words changed.
  - A fresh start is then accepted.
